// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-channel fixed-latency memory responder with backdoor preload
//
// Purpose:
//   Word-addressed storage shared by NUM_CHANNELS independent valid/ready
//   request channels. Each channel serves one read or write at a time and
//   raises a one-cycle ready pulse a fixed number of edges after it
//   captured the request. A backdoor load port preloads the array.
//
// Ports:
//   clk                clock, all state updates on rising edge
//   reset              asynchronous active-low reset
//   mem_read_valid     per-channel read request
//   mem_read_address   per-channel read address, channel c at [c*ADDR_BITS +: ADDR_BITS]
//   mem_read_ready     per-channel one-cycle read-complete pulse
//   mem_read_data      per-channel read data, channel c at [c*DATA_BITS +: DATA_BITS]
//   mem_write_valid    per-channel write request
//   mem_write_address  per-channel write address
//   mem_write_data     per-channel write data
//   mem_write_ready    per-channel one-cycle write-complete pulse
//   load_en            backdoor preload strobe
//   load_address       backdoor preload address
//   load_data          backdoor preload data

module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 1,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_en,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  localparam int DEPTH    = 2 ** ADDR_BITS;
  localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  // Counter only ever holds LATENCY-1, so clog2(MAX_LAT) bits suffice.
  localparam int CNT_BITS = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_BUSY = 3'd1,
    S_WR_BUSY = 3'd2,
    S_RESPOND = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  // Storage is intentionally not reset so preloaded contents survive reset.
  logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];

  logic [NUM_CHANNELS-1:0] w_wr_commit;
  logic [ADDR_BITS-1:0]    w_wr_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    w_wr_data [NUM_CHANNELS];

  // Later non-blocking writes override earlier ones on the same edge: the
  // backdoor goes first (lowest priority), then channels from highest to
  // lowest so channel 0 wins an address collision.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_address] <= load_data;
    end
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (w_wr_commit[c]) begin
        r_mem[w_wr_addr[c]] <= w_wr_data[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_BITS-1:0]  r_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_is_rd;

    logic w_rd_valid;
    logic w_wr_valid;
    logic w_cap_rd;
    logic w_cap_wr;
    logic w_rd_done;
    logic w_wr_done;

    assign w_rd_valid = mem_read_valid[g];
    assign w_wr_valid = mem_write_valid[g];

    always_comb begin
      w_state_nxt = r_state;
      w_cap_rd    = 1'b0;
      w_cap_wr    = 1'b0;
      w_rd_done   = 1'b0;
      w_wr_done   = 1'b0;
      case (r_state)
        S_IDLE: begin
          // Read has priority; a concurrent write simply stays pending.
          if (w_rd_valid) begin
            w_cap_rd    = 1'b1;
            w_state_nxt = S_RD_BUSY;
          end else if (w_wr_valid) begin
            w_cap_wr    = 1'b1;
            w_state_nxt = S_WR_BUSY;
          end
        end
        S_RD_BUSY: begin
          if (r_cnt == '0) begin
            w_rd_done   = 1'b1;
            w_state_nxt = S_RESPOND;
          end
        end
        S_WR_BUSY: begin
          if (r_cnt == '0) begin
            w_wr_done   = 1'b1;
            w_state_nxt = S_RESPOND;
          end
        end
        S_RESPOND: begin
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          // Wait for the initiator to withdraw the request just served so
          // a still-asserted valid is not mistaken for a new request.
          if (r_is_rd ? !w_rd_valid : !w_wr_valid) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_rdata <= '0;
        r_is_rd <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_cap_rd) begin
          r_addr  <= mem_read_address[g*ADDR_BITS +: ADDR_BITS];
          r_cnt   <= RD_LOAD;
          r_is_rd <= 1'b1;
        end else if (w_cap_wr) begin
          r_addr  <= mem_write_address[g*ADDR_BITS +: ADDR_BITS];
          r_wdata <= mem_write_data[g*DATA_BITS +: DATA_BITS];
          r_cnt   <= WR_LOAD;
          r_is_rd <= 1'b0;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
        // Sampling the array with a non-blocking read yields the pre-edge
        // word, giving read-before-write against same-edge commits.
        if (w_rd_done) begin
          r_rdata <= r_mem[r_addr];
        end
      end
    end

    // Ready is decoded from RESPOND, so it drops the instant reset asserts.
    assign mem_read_ready[g]                         = (r_state == S_RESPOND) && r_is_rd;
    assign mem_write_ready[g]                        = (r_state == S_RESPOND) && !r_is_rd;
    assign mem_read_data[g*DATA_BITS +: DATA_BITS]   = r_rdata;

    assign w_wr_commit[g] = w_wr_done;
    assign w_wr_addr[g]   = r_addr;
    assign w_wr_data[g]   = r_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder with a behavioural memory model

module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 16;
  localparam int NCH = 2;
  localparam int RL  = 2;
  localparam int WL  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rv0, rv1, wv0, wv1;
  logic [7:0]  ra0, ra1, wa0, wa1;
  logic [15:0] wd0, wd1;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_ready;
  logic [31:0] rd_data;

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .mem_read_valid   ({rv1, rv0}),
    .mem_read_address ({ra1, ra0}),
    .mem_read_ready   (rd_ready),
    .mem_read_data    (rd_data),
    .mem_write_valid  ({wv1, wv0}),
    .mem_write_address({wa1, wa0}),
    .mem_write_data   ({wd1, wd0}),
    .mem_write_ready  (wr_ready),
    .load_en          (load_en),
    .load_address     (load_addr),
    .load_data        (load_data)
  );

  typedef struct {
    int          ch;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] data;
    int          due;
  } txn_t;

  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [15:0] data;
  } ld_t;

  txn_t        exp_q[$];
  ld_t         ld_q[$];
  logic [15:0] model_mem [256];
  logic [15:0] last_rd [2];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find_txn(input int c, input bit wr);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].ch == c && exp_q[i].wr == wr) return i;
    return -1;
  endfunction

  // Monitor: reads see the array before this edge's writes; then loads,
  // then channel writes highest-to-lowest so channel 0 lands last.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rd[0] = '0;
        last_rd[1] = '0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (rd_ready[c]) begin
            k = find_txn(c, 1'b0);
            if (k < 0) begin
              tests++; fails++;
              $display("FAIL unexpected_rd_ready ch%0d: got 1 expected 0 (cycle %0d)", c, cyc);
            end else begin
              chk($sformatf("rd_latency_ch%0d", c), cyc, exp_q[k].due);
              chk($sformatf("rd_data_ch%0d_a%h", c, exp_q[k].addr), {16'h0, rd_data[c*16 +: 16]},
                  {16'h0, model_mem[exp_q[k].addr]});
              last_rd[c] = model_mem[exp_q[k].addr];
              exp_q.delete(k);
            end
          end else begin
            chk($sformatf("rd_data_hold_ch%0d", c), {16'h0, rd_data[c*16 +: 16]}, {16'h0, last_rd[c]});
          end
        end
        while (ld_q.size() > 0 && ld_q[0].due == cyc) begin
          model_mem[ld_q[0].addr] = ld_q[0].data;
          void'(ld_q.pop_front());
        end
        for (int c = 1; c >= 0; c--) begin
          if (wr_ready[c]) begin
            k = find_txn(c, 1'b1);
            if (k < 0) begin
              tests++; fails++;
              $display("FAIL unexpected_wr_ready ch%0d: got 1 expected 0 (cycle %0d)", c, cyc);
            end else begin
              chk($sformatf("wr_latency_ch%0d", c), cyc, exp_q[k].due);
              model_mem[exp_q[k].addr] = exp_q[k].data;
              exp_q.delete(k);
            end
          end
        end
      end
    end
  end

  task automatic drive(input int c, input bit wr, input logic v, input logic [7:0] a, input logic [15:0] d);
    if (c == 0) begin
      if (wr) begin wv0 = v; wa0 = a; wd0 = d; end
      else    begin rv0 = v; ra0 = a; end
    end else begin
      if (wr) begin wv1 = v; wa1 = a; wd1 = d; end
      else    begin rv1 = v; ra1 = a; end
    end
  endtask

  // One request: valid held until ready plus 'extra' cycles, then dropped
  // for just long enough that the next call is accepted immediately.
  task automatic chan_op(input int c, input bit wr, input logic [7:0] a, input logic [15:0] d, input int extra);
    txn_t t;
    bit   seen;
    @(negedge clk);
    t.ch = c; t.wr = wr; t.addr = a; t.data = d;
    t.due = cyc + 1 + (wr ? WL : RL);
    exp_q.push_back(t);
    drive(c, wr, 1'b1, a, d);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) drive(c, wr, 1'b1, ~a, ~d);
      seen = wr ? wr_ready[c] : rd_ready[c];
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL timeout_ch%0d: got no ready expected ready (cycle %0d)", c, cyc);
    end
    repeat (extra) @(negedge clk);
    drive(c, wr, 1'b0, a, d);
    if (extra == 0) @(negedge clk);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    ld_t l;
    load_en = 1'b1; load_addr = a; load_data = d;
    l.due = cyc + 1; l.addr = a; l.data = d;
    ld_q.push_back(l);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    bit   seen;
    int   r;
    rst_n = 1'b0;
    rv0 = 0; rv1 = 0; wv0 = 0; wv1 = 0;
    ra0 = 0; ra1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    last_rd[0] = '0; last_rd[1] = '0;

    repeat (3) @(negedge clk);
    chk("reset_rd_ready", {30'h0, rd_ready}, 32'h0);
    chk("reset_wr_ready", {30'h0, wr_ready}, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    #2 rst_n = 1'b1;

    // Preload every word so all later reads have a defined expectation.
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i == 8'h10) v = 16'h1234;
      if (i == 8'h30) v = 16'h5555;
      load_word(8'(i), v);
    end

    chan_op(0, 1'b0, 8'h10, 16'h0, 0);
    chk("rd_0x10", {16'h0, rd_data[15:0]}, 32'h1234);

    chan_op(0, 1'b1, 8'h20, 16'hBEEF, 0);
    chan_op(0, 1'b0, 8'h20, 16'h0, 0);
    chk("rd_0x20", {16'h0, rd_data[15:0]}, 32'hBEEF);

    // Valid held five cycles past ready, then a one-cycle drop.
    chan_op(0, 1'b0, 8'h10, 16'h0, 5);
    chan_op(0, 1'b0, 8'h20, 16'h0, 0);

    // Same-edge write on ch0 and read on ch1 to one address.
    fork
      chan_op(0, 1'b1, 8'h30, 16'hAAAA, 0);
      chan_op(1, 1'b0, 8'h30, 16'h0, 0);
    join
    chk("rbw_old_word", {16'h0, rd_data[31:16]}, 32'h5555);
    chan_op(1, 1'b0, 8'h30, 16'h0, 0);
    chk("rbw_new_word", {16'h0, rd_data[31:16]}, 32'hAAAA);

    fork
      chan_op(0, 1'b1, 8'h40, 16'h1111, 0);
      chan_op(1, 1'b1, 8'h40, 16'h2222, 0);
    join
    chan_op(1, 1'b0, 8'h40, 16'h0, 0);
    chk("ww_ch0_wins", {16'h0, rd_data[31:16]}, 32'h1111);

    // Backdoor load lands on the same edge the ch0 write commits.
    fork
      chan_op(0, 1'b1, 8'h50, 16'h7777, 0);
      begin
        repeat (3) @(negedge clk);
        load_word(8'h50, 16'h9999);
      end
    join
    chan_op(0, 1'b0, 8'h50, 16'h0, 0);
    chk("load_loses", {16'h0, rd_data[15:0]}, 32'h7777);

    // Read and write both valid in IDLE: read first, write after HOLD exit.
    @(negedge clk);
    rv0 = 1; ra0 = 8'h10; wv0 = 1; wa0 = 8'h60; wd0 = 16'hCAFE;
    t.ch = 0; t.wr = 0; t.addr = 8'h10; t.data = 0; t.due = cyc + 1 + RL;
    exp_q.push_back(t);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rd_ready[0]; end
    chk("both_rd_seen", {31'h0, seen}, 32'h1);
    t.wr = 1; t.addr = 8'h60; t.data = 16'hCAFE; t.due = cyc + 3 + WL;
    exp_q.push_back(t);
    rv0 = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = wr_ready[0]; end
    chk("both_wr_seen", {31'h0, seen}, 32'h1);
    wv0 = 0;
    @(negedge clk);
    chan_op(0, 1'b0, 8'h60, 16'h0, 0);
    chk("both_wr_data", {16'h0, rd_data[15:0]}, 32'hCAFE);

    // Reset while a read is in flight: dropped, outputs cleared at once.
    @(negedge clk);
    rv0 = 1; ra0 = 8'h20;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_ready", {30'h0, rd_ready}, 32'h0);
    chk("rst_mid_rd_data", rd_data, 32'h0);
    rv0 = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chan_op(0, 1'b0, 8'h10, 16'h0, 0);
    chk("after_rst_data", {16'h0, rd_data[15:0]}, 32'h1234);

    // Randomised traffic over a small address window to force collisions.
    fork
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chan_op(0, 1'($urandom), 8'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 3)));
      end
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chan_op(1, 1'($urandom), 8'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 3)));
      end
      for (int n = 0; n < 20; n++) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        load_word(8'($urandom_range(0, 7)), 16'($urandom));
      end
    join

    repeat (6) @(negedge clk);
    r = exp_q.size();
    chk("scoreboard_empty", r, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the flattened per-channel valid/ready memory interface that the consumer-to-memory controller drives.
- Holds a word-addressed storage array shared by all channels and serves each channel's read or write after a fixed, programmable latency.
- Serves as the data/program memory model behind the controller in simulation and as the synthesizable on-chip scratch memory in small builds.

Parameters:
ADDR_BITS, 8, address width; array depth = 2**ADDR_BITS words
DATA_BITS, 16, word width
NUM_CHANNELS, 1, independent request channels
READ_LATENCY, 2, edges from request capture to read ready; legal range >= 1
WRITE_LATENCY, 2, edges from request capture to write ready; legal range >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
mem_read_valid  input  NUM_CHANNELS  per-channel read request
mem_read_address  input  NUM_CHANNELS*ADDR_BITS  channel c at [c*ADDR_BITS +: ADDR_BITS]
mem_read_ready  output  NUM_CHANNELS  one-cycle read-complete pulse
mem_read_data  output  NUM_CHANNELS*DATA_BITS  channel c at [c*DATA_BITS +: DATA_BITS]
mem_write_valid  input  NUM_CHANNELS  per-channel write request
mem_write_address  input  NUM_CHANNELS*ADDR_BITS  write address, same slicing
mem_write_data  input  NUM_CHANNELS*DATA_BITS  write data, same slicing
mem_write_ready  output  NUM_CHANNELS  one-cycle write-complete pulse
load_en  input  1  backdoor preload strobe
load_address  input  ADDR_BITS  backdoor preload address
load_data  input  DATA_BITS  backdoor preload data

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: mem_read_ready=0, mem_write_ready=0, mem_read_data=0.
  - State: all channel FSMs in IDLE, latency counters 0.
  - Storage array is not cleared.
  - Reset mid-operation drops any in-flight request; no ready pulse is issued for it.
- Per-channel FSM, states IDLE, RD_BUSY, WR_BUSY, RESPOND, HOLD:
  - IDLE: at an edge where read_valid=1, capture the address and load the counter with READ_LATENCY-1; go to RD_BUSY.
    - Else, at an edge where write_valid=1, capture address and data and load the counter with WRITE_LATENCY-1; go to WR_BUSY.
    - If both are valid, read wins and the write stays pending.
  - RD_BUSY / WR_BUSY: decrement the counter each edge.
    - At the edge where the counter is 0, complete the access and go to RESPOND.
    - Read completion: registers array[captured address] onto the channel's data slice and sets read_ready=1.
    - Write completion: commits array[captured address] = captured data and sets write_ready=1.
  - RESPOND: at the next edge clear ready (ready is high for exactly one cycle); go to HOLD.
  - HOLD: stay until the corresponding valid is sampled 0, then go to IDLE.
    - This prevents re-serving a request the initiator has not yet withdrawn.
- Latency:
  - Request captured at edge k; ready is visible from edge k+LATENCY to edge k+LATENCY+1.
  - Minimum back-to-back spacing per channel is LATENCY+2 edges plus the initiator's valid-low cycle.
- Address and data are captured at request time; later changes on the input bus are ignored.
- mem_read_data holds its last value until the next read completes on that channel.
- Same-edge collisions across channels:
  - Read and write to the same address on the same edge: the read returns the old word (read-before-write).
  - Two writes to the same address on the same edge: the lowest-numbered channel wins.
  - load_en writes at an edge: the backdoor load has lowest priority against channel writes to the same address.
- Addresses wrap naturally within ADDR_BITS; there is no out-of-range case.

Test Plan:
- Preload array[0x10]=0x1234 via load port; ch0 read 0x10 with READ_LATENCY=2, valid held until ready → read_ready high exactly one cycle, 2 edges after capture, data=0x1234.
- Ch0 write 0x20←0xBEEF, drop valid after ready, then read 0x20 → write_ready one pulse after 2 edges; read returns 0xBEEF.
- Hold read_valid high 5 cycles after ready → exactly one ready pulse; after valid drops for one cycle, the next request is accepted.
- NUM_CHANNELS=2: ch0 writes 0x30←0xAAAA and ch1 reads 0x30 on the same edge, array[0x30]=0x5555 → ch1 gets 0x5555, later read gets 0xAAAA; both channels write 0x40 on the same edge → ch0's data stored.
- Read and write both valid in IDLE → read served first; write served after the read's HOLD exits.
- Pull reset low during RD_BUSY → ready stays 0, outputs 0 immediately; after release, a fresh read completes normally and array contents are preserved.
